fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core, sitting directly upstream of the control path and datapath. It owns the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and holds it stable in an instruction register. It presents `opcode`/`funct` and an execute strobe downstream. It consumes the control path's jump/branch decisions to compute the next PC.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, downstream-issue and jump-control bundle
//               around the fetch stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        JBEQ;
    logic        JJRJAL;
    logic        JR;
    logic [31:0] rs_data;
    logic        stall;
    logic        misalign;

    modport master (
        output imem_req, imem_addr, instr, opcode, funct, instr_valid,
               pc, pc_plus4, misalign,
        input  imem_ack, imem_rdata, JBEQ, JJRJAL, JR, rs_data, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, funct, instr_valid,
               pc, pc_plus4, misalign,
        output imem_ack, imem_rdata, JBEQ, JJRJAL, JR, rs_data, stall
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction-fetch stage: PC, req/ack fetch, instruction
//               register and next-PC selection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        misalign_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] pc_d;
    logic        jr_misalign;

    assign pc_plus4    = pc_q + 32'd4;
    assign br_offset   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jr_misalign = bus.JR && (bus.rs_data[1:0] != 2'b00);

    // JR outranks J/JAL, which outranks a taken branch.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.JR) begin
            pc_d = {bus.rs_data[31:2], 2'b00};
        end else if (bus.JJRJAL) begin
            pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (bus.JBEQ) begin
            pc_d = pc_plus4 + br_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= 32'd0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!bus.stall) begin
                        pc_q    <= pc_d;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        if (jr_misalign) begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit: memory/control driver plus an
//               independent monitor checking fetch addresses and issued words.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        int          gap;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    int n_checks;
    int n_errs;

    logic [31:0] m_pc;
    logic        m_mis;
    int          prev_s;
    bit          first_issue;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference next-PC computed from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input logic [31:0] rs, input logic jr,
                                               input logic j, input logic beq);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (jr) return rs & 32'hFFFF_FFFC;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
        if (beq) begin
            off = $signed(w[15:0]);
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    // Monitor: checks every new fetch request and every issued instruction.
    initial begin : monitor
        logic        req_prev;
        logic        val_prev;
        logic [31:0] cur_addr;
        exp_t        cur;
        int          cyc;
        int          last_rise;
        req_prev  = 1'b0;
        val_prev  = 1'b0;
        cur_addr  = 32'd0;
        cur       = '{pc: 32'd0, instr: 32'd0, mis: 1'b0, gap: 0};
        cyc       = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                req_prev = 1'b0;
                val_prev = 1'b0;
            end else begin
                if (bus.imem_req && !req_prev) begin
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_fetch: request at %h, none required", bus.imem_addr);
                    end else begin
                        cur_addr = addr_q.pop_front();
                        chk("fetch_addr", bus.imem_addr, cur_addr);
                    end
                end else if (bus.imem_req) begin
                    chk("fetch_addr_stable", bus.imem_addr, cur_addr);
                end
                if (bus.imem_req && bus.instr_valid) begin
                    chk("req_during_exec", {31'd0, bus.imem_req}, 32'd0);
                end
                if (bus.instr_valid && !val_prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_issue: instr %h issued, none required", bus.instr);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("issue_pc", bus.pc, cur.pc);
                        chk("issue_pc_plus4", bus.pc_plus4, cur.pc + 32'd4);
                        chk("issue_instr", bus.instr, cur.instr);
                        chk("issue_opcode", {26'd0, bus.opcode}, {26'd0, cur.instr[31:26]});
                        chk("issue_funct", {26'd0, bus.funct}, {26'd0, cur.instr[5:0]});
                        chk("issue_misalign", {31'd0, bus.misalign}, {31'd0, cur.mis});
                        if (cur.gap != 0) begin
                            chk("issue_period", cyc - last_rise, cur.gap);
                        end
                    end
                    last_rise = cyc;
                end else if (bus.instr_valid) begin
                    chk("hold_pc", bus.pc, cur.pc);
                    chk("hold_instr", bus.instr, cur.instr);
                end
                req_prev = bus.imem_req;
                val_prev = bus.instr_valid;
            end
        end
    end

    // One instruction: ack after lat wait cycles, then st stall cycles in EXEC.
    task automatic do_instr(input int lat, input int st, input logic [31:0] w,
                            input logic jr, input logic j, input logic beq,
                            input logic [31:0] rs, input bit spur);
        int   t;
        exp_t e;
        t = 0;
        while (!bus.imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.imem_req) begin
            n_checks++;
            n_errs++;
            $display("FAIL fetch_timeout: imem_req=0 after %0d cycles, required 1", t);
            return;
        end
        bus.imem_ack = 1'b0;
        repeat (lat) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        e.pc    = m_pc;
        e.instr = w;
        e.mis   = m_mis;
        e.gap   = first_issue ? 0 : (prev_s + 1 + lat + 1);
        first_issue = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.imem_ack   = spur;
        bus.imem_rdata = $urandom;
        repeat (st) begin
            bus.stall   = 1'b1;
            bus.JR      = 1'($urandom);
            bus.JJRJAL  = 1'($urandom);
            bus.JBEQ    = 1'($urandom);
            bus.rs_data = $urandom;
            @(negedge clk);
        end
        bus.stall   = 1'b0;
        bus.JR      = jr;
        bus.JJRJAL  = j;
        bus.JBEQ    = beq;
        bus.rs_data = rs;
        if (jr && rs[1:0] != 2'b00) m_mis = 1'b1;
        m_pc   = model_next(m_pc, w, rs, jr, j, beq);
        prev_s = st;
        addr_q.push_back(m_pc);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.JR       = 1'b0;
        bus.JJRJAL   = 1'b0;
        bus.JBEQ     = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] rs;
        n_checks = 0;
        n_errs   = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.JBEQ       = 1'b0;
        bus.JJRJAL     = 1'b0;
        bus.JR         = 1'b0;
        bus.rs_data    = 32'd0;
        bus.stall      = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        chk("rst_pc", bus.pc, C_RESET_PC);
        chk("rst_addr", bus.imem_addr, C_RESET_PC);
        chk("rst_pc_plus4", bus.pc_plus4, C_RESET_PC + 32'd4);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_opcode", {26'd0, bus.opcode}, 32'd0);
        chk("rst_funct", {26'd0, bus.funct}, 32'd0);

        m_pc = C_RESET_PC;
        m_mis = 1'b0;
        prev_s = 0;
        first_issue = 1'b1;
        addr_q.push_back(m_pc);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);

        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 32'd0, 0);
        do_instr(0, 0, 32'h0000_0020, 0, 0, 0, 32'd0, 0);
        do_instr(3, 0, 32'h0000_0008, 1, 0, 0, 32'h0000_0100, 1);
        do_instr(0, 0, 32'h1000_FFFF, 0, 0, 1, 32'd0, 0);
        do_instr(1, 0, 32'h1000_0003, 0, 0, 1, 32'd0, 0);
        do_instr(0, 0, 32'h0000_0008, 1, 0, 0, 32'h3000_0000, 0);
        do_instr(2, 0, 32'h0800_0010, 0, 1, 0, 32'd0, 0);
        do_instr(0, 0, 32'h0000_0008, 1, 1, 0, 32'h0000_2003, 0);
        do_instr(0, 5, 32'h0000_0025, 0, 0, 0, 32'd0, 1);
        do_instr(0, 0, 32'h0000_0008, 1, 0, 0, 32'hFFFF_FFFC, 0);
        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 32'd0, 0);
        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 32'd0, 0);

        for (int i = 0; i < 150; i++) begin
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            do_instr($urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 3) == 0), rs, 1'($urandom));
        end

        // Reset during an ack wait; a late ack right after release must be ignored.
        bus.imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_async_pc", bus.pc, C_RESET_PC);
        chk("rst_async_misalign", {31'd0, bus.misalign}, 32'd0);
        chk("rst_async_instr", bus.instr, 32'd0);
        chk("rst_pending_issue", exp_q.size(), 32'd0);
        m_pc = C_RESET_PC;
        m_mis = 1'b0;
        prev_s = 0;
        first_issue = 1'b1;
        addr_q.push_back(m_pc);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.imem_ack = 1'b0;
        @(negedge clk);

        do_instr(1, 0, 32'h0000_0021, 0, 0, 0, 32'd0, 0);
        do_instr(0, 0, 32'h0000_0008, 1, 0, 0, 32'h0000_0501, 0);
        do_instr(0, 1, 32'h0000_0000, 0, 0, 0, 32'd0, 0);

        repeat (4) @(negedge clk);
        chk("drain_issue", exp_q.size(), 32'd0);
        chk("drain_fetch", addr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
